// File: rtl/sr_cmd_conditioner.sv
// sr_cmd_conditioner: synchronises and debounces raw set/reset requests, then issues
// spaced single-cycle S/R pulses to an SR flip-flop. Optional macro: SR_RESET_PRIORITY_EN.
`default_nettype none

module sr_cmd_conditioner #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned HOLDOFF   = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic reset_req,
    output logic S,
    output logic R,
    output logic conflict,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    logic [1:0] req_raw;
    logic [1:0] db_rise;
    logic [1:0] pend_q;
    logic [1:0] pend_d;
    state_t     state_q;
    logic [3:0] hold_q;

    assign req_raw = {reset_req, set_req};

    // Channel 0 is set, channel 1 is reset.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_ch
            logic       sync1_q;
            logic       sync2_q;
            logic       db_q;
            logic [7:0] cnt_q;
            logic [7:0] cnt_inc;

            assign cnt_inc    = cnt_q + 8'd1;
            assign db_rise[g] = (sync2_q != db_q) && (cnt_inc == 8'(DB_CYCLES)) && !db_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    db_q    <= 1'b0;
                    cnt_q   <= 8'd0;
                end else begin
                    sync1_q <= req_raw[g];
                    sync2_q <= sync1_q;
                    if (sync2_q == db_q) begin
                        cnt_q <= 8'd0;
                    end else if (cnt_inc == 8'(DB_CYCLES)) begin
                        cnt_q <= 8'd0;
                        db_q  <= sync2_q;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
            end
        end
    endgenerate

    // New debounced events merge into the flags even while they are being consumed.
    assign pend_d = pend_q | db_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            hold_q   <= 4'd0;
            pend_q   <= 2'b00;
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
            busy     <= 1'b0;
        end else begin
            S        <= 1'b0;
            R        <= 1'b0;
            conflict <= 1'b0;
            pend_q   <= pend_d;
            case (state_q)
                IDLE: begin
                    busy <= 1'b0;
                    if (pend_q == 2'b11) begin
                        pend_q   <= db_rise;
                        conflict <= 1'b1;
`ifdef SR_RESET_PRIORITY_EN
                        R       <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= PULSE;
`else
                        state_q <= IDLE;
`endif
                    end else if (pend_q[0]) begin
                        pend_q  <= {pend_q[1], 1'b0} | db_rise;
                        S       <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= PULSE;
                    end else if (pend_q[1]) begin
                        pend_q  <= {1'b0, pend_q[0]} | db_rise;
                        R       <= 1'b1;
                        busy    <= 1'b1;
                        state_q <= PULSE;
                    end
                end
                PULSE: begin
                    busy    <= 1'b1;
                    hold_q  <= 4'd0;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (hold_q == 4'(HOLDOFF - 1)) begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        busy   <= 1'b1;
                        hold_q <= hold_q + 4'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
